// File: rtl/wb_dma_ch_rr_arb.sv
// wb_dma_ch_rr_arb
// Round-robin channel arbiter that sits after the channel priority encoder.
// A channel is eligible when it requests and its priority matches pri_out.
// The winner is the first eligible channel after the last one granted, and
// it keeps the grant until the engine pulses next or the channel stops
// requesting. A dead cycle follows every release so that pri_out can settle.

module wb_dma_ch_rr_arb #(
  parameter int CH_NUM = 31,
  parameter int PRI_W  = 3,
  parameter int CH_W   = 5
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [CH_NUM-1:0]       valid,
  input  logic [CH_NUM*PRI_W-1:0] pri,
  input  logic [PRI_W-1:0]        pri_out,
  input  logic                    next,
  output logic                    grant_valid,
  output logic [CH_W-1:0]         grant_ch,
  output logic [CH_NUM-1:0]       grant,
  output logic                    busy
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] GRANT = 2'd1;
  localparam logic [1:0] REL   = 2'd2;

  logic [1:0]        state;
  logic [CH_W-1:0]   last_ch;
  logic [CH_NUM-1:0] elig;
  logic              found;
  logic [CH_W-1:0]   win_ch;
  logic [CH_NUM-1:0] win_oh;
  logic              release_req;
  int                scan_idx;

  // Eligible set: requesting channels whose priority matches the encoder output.
  always_comb begin
    // NOTE: every combinational output gets a default before any branch or
    // loop, so no path leaves it unassigned and no latch is inferred.
    elig = '0;
    for (int n = 0; n < CH_NUM; n++) begin
      elig[n] = valid[n] && (pri[n*PRI_W +: PRI_W] == pri_out);
    end
  end

  // Round-robin scan starting one past last_ch, wrapping CH_NUM-1 -> 0.
  // Offset CH_NUM lands back on last_ch, so a lone eligible last_ch re-wins.
  always_comb begin
    found    = 1'b0;
    win_ch   = '0;
    scan_idx = 0;
    for (int k = 1; k <= CH_NUM; k++) begin
      scan_idx = int'(last_ch) + k;
      if (scan_idx >= CH_NUM) scan_idx = scan_idx - CH_NUM;
      if (!found && elig[scan_idx]) begin
        found  = 1'b1;
        win_ch = CH_W'(scan_idx);
      end
    end
  end

  // One-hot form of the winner for the channel mux.
  always_comb begin
    win_oh         = '0;
    win_oh[win_ch] = 1'b1;
  end

  // The grant ends on next or when the granted channel withdraws its request;
  // both together still produce a single release.
  assign release_req = next || !(|(valid & grant));

  assign busy = (state != IDLE);

  // Arbitration FSM and registered grant outputs; reset wins over everything.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    if (rst) begin
      state       <= IDLE;
      grant_valid <= 1'b0;
      grant_ch    <= '0;
      grant       <= '0;
      last_ch     <= CH_W'(CH_NUM - 1);
    end else begin
      case (state)
        IDLE: begin
          if (found) begin
            grant_ch    <= win_ch;
            grant       <= win_oh;
            grant_valid <= 1'b1;
            last_ch     <= win_ch;
            state       <= GRANT;
          end
        end
        GRANT: begin
          if (release_req) begin
            grant_valid <= 1'b0;
            grant       <= '0;
            state       <= REL;
          end
        end
        REL:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
